// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore front end: data widths, PC step,
// default reset PC and the instruction-queue entry layout.
package fewcore_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One instruction-queue slot: the fetched word tagged with its address
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] word;
    } iq_entry_t;

    // Instruction addresses are always word aligned; low two bits are dropped
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Small circular FIFO with registered storage, synchronous clear and an
// occupancy count. The head word is a plain read of the storage register, so
// it is stable while nothing is popped.
module sync_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointer advance with explicit wrap so any depth works
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Status flags and qualified push/pop; clear overrides both
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        pop_ok  = pop && !clear && !empty;
        push_ok = push && !clear && (!full || pop_ok);
        dout    = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage; cleared on reset so the head reads as zero out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch buffer. Issues sequential word reads to instruction
// memory under a credit limit, queues returned words with their PCs and hands
// them to fetch over valid/ready. A redirect from execute flushes the queue,
// retargets the fetch PC and marks every read still in flight as stale.
module fetch_prefetch_queue
    import fewcore_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready,
    input  logic              originPc,
    input  logic [XLEN-1:0]   pcBranch
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] next_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;

    // Instruction queue signals
    iq_entry_t       iq_din;
    iq_entry_t       iq_dout;
    logic [CW-1:0]   iq_count;
    logic            iq_full;
    logic            iq_empty;

    // In-flight PC FIFO signals
    logic [XLEN-1:0] pc_head;
    logic [OW-1:0]   pc_count;
    logic            pc_full;
    logic            pc_empty;

    logic [CW:0]     in_use;
    logic            has_credit;
    logic            below_max;
    logic            grant;
    logic            keep;
    logic            deq;

    // Issue and handshake decode. A slot is committed to a read as soon as it
    // is granted, so queued plus in-flight never exceeds the queue depth.
    always_comb begin
        in_use     = (CW + 1)'(iq_count) + (CW + 1)'(outstanding);
        has_credit = in_use < (CW + 1)'(DEPTH);
        below_max  = outstanding < OW'(MAX_OUT);
        imem_req   = reset && !originPc && has_credit && below_max;
        imem_addr  = next_pc;
        grant      = imem_req && imem_gnt;
        keep       = imem_rvalid && !originPc && (discard == '0);
        inst_valid = !iq_empty && !originPc;
        deq        = inst_valid && inst_ready;
        iq_din     = '{pc: pc_head, word: imem_rdata};
        inst       = iq_dout.word;
        inst_pc    = iq_dout.pc;
    end

    // Fetch PC: jump to the aligned target on redirect, else step per grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_pc <= RESET_PC;
        end else if (originPc) begin
            next_pc <= align_pc(pcBranch);
        end else if (grant) begin
            next_pc <= next_pc + PC_STEP;
        end
    end

    // Reads granted but not yet answered, stale ones included
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else if (grant && !imem_rvalid) begin
            outstanding <= outstanding + OW'(1);
        end else if (imem_rvalid && !grant) begin
            outstanding <= outstanding - OW'(1);
        end
    end

    // Stale responses still to drop. On redirect every read that is still in
    // flight after this cycle becomes stale; any response arriving in the
    // redirect cycle itself is dropped directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            discard <= '0;
        end else if (originPc) begin
            discard <= outstanding - OW'(imem_rvalid);
        end else if (imem_rvalid && (discard != '0)) begin
            discard <= discard - OW'(1);
        end
    end

    // Decoded instruction queue holding {pc, word}
    sync_fifo #(
        .WIDTH ($bits(iq_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk   (clk),
        .reset (reset),
        .clear (originPc),
        .push  (keep),
        .din   (iq_din),
        .pop   (deq),
        .dout  (iq_dout),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_count)
    );

    // Addresses of live in-flight reads, consumed in response order
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_pc_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (originPc),
        .push  (grant),
        .din   (next_pc),
        .pop   (keep),
        .dout  (pc_head),
        .full  (pc_full),
        .empty (pc_empty),
        .count (pc_count)
    );

    // Protocol sanity checks; ignored by synthesis
    always @(posedge clk) begin
        if (reset) begin
            assert (!(keep && iq_full));
            assert (!(keep && pc_empty));
            assert (!(grant && pc_full));
            assert (!(imem_rvalid && (outstanding == '0)));
            assert (pc_count <= outstanding);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a transaction-level
// model built from queues of requested addresses and buffered PCs.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        originPc = 1'b0;
    logic [31:0] pcBranch = 32'h0;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .originPc    (originPc),
        .pcBranch    (pcBranch)
    );

    always #5 clk = ~clk;

    // Model: memory requests in flight (oldest first) and buffered PCs
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        infl[$];
    logic [31:0] mq[$];
    logic [31:0] m_next_pc;
    int          cyc;
    int          gnt_pct;
    int          lat_min;
    int          lat_max;
    int          max_inf;
    bit          verbose;

    int n_cmp  = 0;
    int n_fail = 0;

    // Values sampled in the most recent step
    logic        s_req;
    logic        s_gnt;
    logic [31:0] s_addr;
    logic        s_val;
    logic [31:0] s_pc;

    typedef struct {
        bit          org;
        logic [31:0] br;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step(input bit org, input logic [31:0] br, input bit rdy);
        req_t r;
        bit   e_req;
        bit   e_val;
        bit   grant;
        int   lat;
        @(negedge clk);
        originPc   = org;
        pcBranch   = br;
        inst_ready = rdy;
        imem_gnt   = ($urandom_range(99) < gnt_pct);
        if (infl.size() != 0 && infl[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = infl[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req  = imem_req;
        s_gnt  = imem_gnt;
        s_addr = imem_addr;
        s_val  = inst_valid;
        s_pc   = inst_pc;
        e_req = !org && (mq.size() + infl.size() < DEPTH) && (infl.size() < MAX_OUT);
        e_val = (mq.size() != 0) && !org;
        check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        check("imem_addr", imem_addr, m_next_pc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, e_val});
        if (e_val) begin
            check("inst_pc", inst_pc, mq[0]);
            check("inst", inst, mq[0] ^ KEY);
        end
        grant = e_req && imem_gnt;
        if (e_val && rdy) begin
            if (verbose) $display("deliver pc=%h inst=%h cycle %0d", mq[0], mq[0] ^ KEY, cyc);
            void'(mq.pop_front());
        end
        if (imem_rvalid) begin
            r = infl.pop_front();
            if (!r.stale && !org) mq.push_back(r.addr);
        end
        if (org) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_next_pc = {br[31:2], 2'b00};
        end
        if (grant) begin
            lat = $urandom_range(lat_max, lat_min);
            infl.push_back('{addr: m_next_pc, stale: 1'b0, due: cyc + lat});
            m_next_pc += 32'd4;
        end
        if (infl.size() > max_inf) max_inf = infl.size();
        cyc++;
    endtask

    // Assert reset between clock edges, check outputs immediately, then release
    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_imem_addr", imem_addr, RST_PC);
        $display("reset applied at t=%0t", $time);
        mq.delete();
        infl.delete();
        m_next_pc   = RST_PC;
        imem_rvalid = 1'b0;
        originPc    = 1'b0;
        max_inf     = 0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        bit          seen_req;
        bit          seen_val;
        int          guard;
        bit          org;
        logic [31:0] br;

        gnt_pct = 100; lat_min = 1; lat_max = 1; verbose = 1'b0; cyc = 0; max_inf = 0;
        m_next_pc = RST_PC;

        // Reset release, streaming, then redirect coinciding with a response and a ready
        vt[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
        vt[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vt[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
        vt[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vt[5] = '{1'b1, 32'h103, 1'b1, 1'b0, 32'h0000_0014, 1'b0, 32'h0};
        vt[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
        vt[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0};
        vt[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100};
        vt[9] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104};

        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(vt[i].org, vt[i].br, vt[i].rdy);
            check("vec_req", {31'b0, s_req}, {31'b0, vt[i].e_req});
            check("vec_addr", s_addr, vt[i].e_addr);
            check("vec_valid", {31'b0, s_val}, {31'b0, vt[i].e_val});
            if (vt[i].e_val) check("vec_pc", s_pc, vt[i].e_pc);
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h", i, s_req, s_addr, s_val, s_pc);
        end

        // Backpressure: fill the queue, head must hold, then drain without gaps
        apply_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        check("hold_req", {31'b0, s_req}, 32'd0);
        check("hold_valid", {31'b0, s_val}, 32'd1);
        check("hold_pc", s_pc, RST_PC);
        $display("hold: head pc=%h req=%0b after 10 stalled cycles", s_pc, s_req);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check("drain_valid", {31'b0, s_val}, 32'd1);
            check("drain_pc", s_pc, RST_PC + 32'(4 * i));
            $display("drain %0d: pc=%h", i, s_pc);
        end

        // 3-cycle memory: in-flight reads limited to MAX_OUT
        apply_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 1'b1);
        check("max_outstanding", 32'(max_inf), 32'(MAX_OUT));
        $display("slow memory: peak in flight %0d", max_inf);

        // Redirect with two reads in flight: both are dropped, restart at 0x100
        apply_reset();
        guard = 0;
        while (infl.size() < 2 && guard < 20) begin
            step(1'b0, 32'h0, 1'b1);
            guard++;
        end
        check("inflight_before_redirect", 32'(infl.size()), 32'd2);
        step(1'b1, 32'h0000_0103, 1'b1);
        seen_req = 1'b0; seen_val = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (!seen_req && s_req && s_gnt) begin
                seen_req = 1'b1;
                check("redirect_first_addr", s_addr, 32'h0000_0100);
            end
            if (!seen_val && s_val) begin
                seen_val = 1'b1;
                check("redirect_first_pc", s_pc, 32'h0000_0100);
            end
        end
        check("redirect_req_seen", {31'b0, seen_req}, 32'd1);
        check("redirect_out_seen", {31'b0, seen_val}, 32'd1);
        $display("redirect: first request and first output at 0x100");

        // Randomized traffic against the model
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            org = ($urandom_range(99) < 3);
            br  = $urandom;
            if (org) $display("random redirect to %h at cycle %0d", {br[31:2], 2'b00}, cyc);
            step(org, br, ($urandom_range(99) < 70));
        end

        // Asynchronous reset mid-stream, then restart from the reset PC
        apply_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; verbose = 1'b1;
        seen_val = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (!seen_val && s_val) begin
                seen_val = 1'b1;
                check("post_reset_first_pc", s_pc, RST_PC);
            end
        end
        check("post_reset_out_seen", {31'b0, seen_val}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
